// File: rtl/control_unit_if.sv
// Control bus between control_unit and datapath: instruction/condition in, control word out.
interface control_unit_if;
   logic [31:0] IR;
   logic        CON_Out;
   logic        PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin;
   logic        PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout;
   logic        Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, GLR;
   logic [4:0]  OP;
   logic        Run;

   modport master (
      input  IR, CON_Out,
      output PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin,
      output PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout,
      output Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, GLR,
      output OP, Run
   );

   modport slave (
      output IR, CON_Out,
      input  PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin,
      input  PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout,
      input  Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, GLR,
      input  OP, Run
   );
endinterface

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer for the datapath; one control word per Clock.
// Optional HALT state is built only when CU_HALT_EN is defined.
//
// state | meaning
// RESET | all controls 0, Run=1; entered on Clear
// T0    | fetch: PC -> MAR, PC+1
// T1    | fetch: memory read into MDR
// T2    | fetch: MDR -> IR
// T3-T7 | execute steps, decoded from IR[31:27]
// HALT  | all controls 0, Run=0; left only by Clear
module control_unit (
   input  logic                  Clock,
   input  logic                  Clear,
   control_unit_if.master        cu
);
   localparam logic [4:0] ADD_OP  = 5'b00100;
   localparam logic [4:0] OPC_LD  = 5'b00000;
   localparam logic [4:0] OPC_ST  = 5'b00010;
   localparam logic [4:0] OPC_BR  = 5'b10011;
   localparam logic [4:0] OPC_JR  = 5'b10100;
   localparam logic [4:0] OPC_HLT = 5'b11011;

   typedef enum logic [3:0] {
      RESET = 4'd0,
      T0    = 4'd1,
      T1    = 4'd2,
      T2    = 4'd3,
      T3    = 4'd4,
      T4    = 4'd5,
      T5    = 4'd6,
      T6    = 4'd7,
      T7    = 4'd8
`ifdef CU_HALT_EN
      ,HALT = 4'd9
`endif
   } state_t;

   state_t     state;
   logic [4:0] opcode;
   logic       is_ld, is_st, is_alu, is_br, is_jr, is_hlt;

   assign opcode = cu.IR[31:27];
   assign is_ld  = (opcode == OPC_LD);
   assign is_st  = (opcode == OPC_ST);
   assign is_alu = (opcode >= 5'b00011) && (opcode <= 5'b01011);
   assign is_br  = (opcode == OPC_BR);
   assign is_jr  = (opcode == OPC_JR);
   assign is_hlt = (opcode == OPC_HLT);

   always_ff @(posedge Clock) begin
      if (Clear) begin
         state <= RESET;
      end else begin
         case (state)
            RESET: state <= T0;
            T0:    state <= T1;
            T1:    state <= T2;
            T2:    state <= T3;
            T3: begin
               if (is_ld || is_st || is_alu || is_br)
                  state <= T4;
`ifdef CU_HALT_EN
               else if (is_hlt)
                  state <= HALT;
`endif
               else
                  state <= T0;
            end
            T4:    state <= T5;
            T5:    state <= is_alu ? T0 : T6;
            T6:    state <= is_br ? T0 : T7;
            T7:    state <= T0;
`ifdef CU_HALT_EN
            HALT:  state <= HALT;
`endif
            default: state <= RESET;
         endcase
      end
   end

   // Datapath features this sequencer never uses.
   assign cu.HIin     = 1'b0;
   assign cu.LOin     = 1'b0;
   assign cu.HIout    = 1'b0;
   assign cu.LOout    = 1'b0;
   assign cu.ZHighout = 1'b0;
   assign cu.OutPort  = 1'b0;
   assign cu.InPort   = 1'b0;
   assign cu.GLR      = 1'b0;

   always_comb begin
      cu.PCin    = 1'b0;
      cu.IRin    = 1'b0;
      cu.ZHighin = 1'b0;
      cu.ZLowin  = 1'b0;
      cu.MARin   = 1'b0;
      cu.MDRin   = 1'b0;
      cu.Yin     = 1'b0;
      cu.PCout   = 1'b0;
      cu.ZLowout = 1'b0;
      cu.MDRout  = 1'b0;
      cu.Cout    = 1'b0;
      cu.Gra     = 1'b0;
      cu.Grb     = 1'b0;
      cu.Grc     = 1'b0;
      cu.Rin     = 1'b0;
      cu.Rout    = 1'b0;
      cu.BAout   = 1'b0;
      cu.Read    = 1'b0;
      cu.Write   = 1'b0;
      cu.IncPC   = 1'b0;
      cu.CON_In  = 1'b0;
      cu.OP      = 5'b00000;
      cu.Run     = 1'b1;
      case (state)
         T0: begin
            cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1;
         end
         T1: begin
            cu.Read = 1'b1; cu.MDRin = 1'b1;
         end
         T2: begin
            cu.MDRout = 1'b1; cu.IRin = 1'b1;
         end
         T3: begin
            if (is_ld || is_st) begin
               cu.Grb = 1'b1; cu.BAout = 1'b1; cu.Yin = 1'b1;
            end else if (is_alu) begin
               cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1;
            end else if (is_br) begin
               cu.Gra = 1'b1; cu.Rout = 1'b1; cu.CON_In = 1'b1;
            end else if (is_jr) begin
               cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1;
            end
         end
         T4: begin
            if (is_ld || is_st) begin
               cu.Cout = 1'b1; cu.OP = ADD_OP; cu.ZHighin = 1'b1; cu.ZLowin = 1'b1;
            end else if (is_alu) begin
               cu.Grc = 1'b1; cu.Rout = 1'b1; cu.OP = opcode;
               cu.ZHighin = 1'b1; cu.ZLowin = 1'b1;
            end else if (is_br) begin
               cu.PCout = 1'b1; cu.Yin = 1'b1;
            end
         end
         T5: begin
            if (is_ld || is_st) begin
               cu.ZLowout = 1'b1; cu.MARin = 1'b1;
            end else if (is_alu) begin
               cu.ZLowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1;
            end else if (is_br) begin
               cu.Cout = 1'b1; cu.OP = ADD_OP; cu.ZHighin = 1'b1; cu.ZLowin = 1'b1;
            end
         end
         T6: begin
            if (is_ld) begin
               cu.Read = 1'b1; cu.MDRin = 1'b1;
            end else if (is_st) begin
               cu.Gra = 1'b1; cu.Rout = 1'b1; cu.MDRin = 1'b1;
            end else if (is_br) begin
               // branch target is loaded only when the condition flip-flop is set
               cu.ZLowout = 1'b1; cu.PCin = cu.CON_Out;
            end
         end
         T7: begin
            if (is_ld) begin
               cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1;
            end else if (is_st) begin
               cu.Write = 1'b1;
            end
         end
`ifdef CU_HALT_EN
         HALT: cu.Run = 1'b0;
`endif
         default: ;
      endcase
   end

   // HALT opcode only matters when the HALT state exists.
   logic unused_hlt;
   assign unused_hlt = is_hlt;
endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: per-cycle control words compared against hand-derived values.
module tb_control_unit;
   logic Clock;
   logic Clear;
   control_unit_if bus ();

   control_unit dut (
      .Clock (Clock),
      .Clear (Clear),
      .cu    (bus.master)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   localparam logic [28:0] C_PCIN    = 29'd1 << 28;
   localparam logic [28:0] C_IRIN    = 29'd1 << 27;
   localparam logic [28:0] C_ZHIGHIN = 29'd1 << 24;
   localparam logic [28:0] C_ZLOWIN  = 29'd1 << 23;
   localparam logic [28:0] C_MARIN   = 29'd1 << 22;
   localparam logic [28:0] C_MDRIN   = 29'd1 << 21;
   localparam logic [28:0] C_YIN     = 29'd1 << 19;
   localparam logic [28:0] C_PCOUT   = 29'd1 << 18;
   localparam logic [28:0] C_ZLOWOUT = 29'd1 << 14;
   localparam logic [28:0] C_MDROUT  = 29'd1 << 12;
   localparam logic [28:0] C_COUT    = 29'd1 << 11;
   localparam logic [28:0] C_GRA     = 29'd1 << 10;
   localparam logic [28:0] C_GRB     = 29'd1 << 9;
   localparam logic [28:0] C_GRC     = 29'd1 << 8;
   localparam logic [28:0] C_RIN     = 29'd1 << 7;
   localparam logic [28:0] C_ROUT    = 29'd1 << 6;
   localparam logic [28:0] C_BAOUT   = 29'd1 << 5;
   localparam logic [28:0] C_READ    = 29'd1 << 4;
   localparam logic [28:0] C_WRITE   = 29'd1 << 3;
   localparam logic [28:0] C_INCPC   = 29'd1 << 2;
   localparam logic [28:0] C_CONIN   = 29'd1 << 1;

   localparam logic [28:0] W_F0   = C_PCOUT | C_MARIN | C_INCPC;
   localparam logic [28:0] W_F1   = C_READ | C_MDRIN;
   localparam logic [28:0] W_F2   = C_MDROUT | C_IRIN;
   localparam logic [28:0] W_ADDR3 = C_GRB | C_BAOUT | C_YIN;
   localparam logic [28:0] W_ADDR4 = C_COUT | C_ZHIGHIN | C_ZLOWIN;
   localparam logic [28:0] W_ADDR5 = C_ZLOWOUT | C_MARIN;
   localparam logic [4:0]  ADD     = 5'b00100;

   typedef struct {
      logic        clr;
      logic [31:0] ir;
      logic        con;
      logic        chk;
      logic [28:0] word;
      logic [4:0]  op;
      logic        run;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [28:0] actual_word();
      return {bus.PCin, bus.IRin, bus.HIin, bus.LOin, bus.ZHighin, bus.ZLowin, bus.MARin,
              bus.MDRin, bus.OutPort, bus.Yin, bus.PCout, bus.HIout, bus.LOout, bus.ZHighout,
              bus.ZLowout, bus.InPort, bus.MDRout, bus.Cout, bus.Gra, bus.Grb, bus.Grc,
              bus.Rin, bus.Rout, bus.BAout, bus.Read, bus.Write, bus.IncPC, bus.CON_In, bus.GLR};
   endfunction

   function automatic void add(logic clr, logic [31:0] ir, logic con, logic chk,
                               logic [28:0] word, logic [4:0] op);
      vec_t v;
      v.clr = clr; v.ir = ir; v.con = con; v.chk = chk;
      v.word = word; v.op = op; v.run = 1'b1;
      vecs.push_back(v);
   endfunction

   function automatic void fetch(logic [31:0] ir);
      add(0, ir, 0, 1, W_F0, 5'd0);
      add(0, ir, 0, 1, W_F1, 5'd0);
      add(0, ir, 0, 1, W_F2, 5'd0);
   endfunction

   task automatic step(input logic clr, input logic [31:0] ir, input logic con, input logic chk,
                       input logic [28:0] word, input logic [4:0] op, input logic run,
                       input string name);
      @(posedge Clock);
      #1;
      Clear       = clr;
      bus.IR      = ir;
      bus.CON_Out = con;
      @(negedge Clock);
      if (chk) begin
         checks++;
         if (actual_word() !== word || bus.OP !== op || bus.Run !== run) begin
            errors++;
            $display("FAIL %s: got word=%h OP=%b Run=%b, expected word=%h OP=%b Run=%b",
                     name, actual_word(), bus.OP, bus.Run, word, op, run);
         end
      end
   endtask

   initial begin
      Clear       = 1'b1;
      bus.IR      = 32'h0;
      bus.CON_Out = 1'b0;

      // reset
      add(1, 32'h0, 0, 0, 29'd0, 5'd0);
      add(1, 32'h0, 0, 1, 29'd0, 5'd0);
      add(0, 32'h0, 0, 1, 29'd0, 5'd0);
      // ADD R1,R2,R3
      fetch(32'h20918000);
      add(0, 32'h20918000, 0, 1, C_GRB | C_ROUT | C_YIN, 5'd0);
      add(0, 32'h20918000, 0, 1, C_GRC | C_ROUT | C_ZHIGHIN | C_ZLOWIN, ADD);
      add(0, 32'h20918000, 0, 1, C_ZLOWOUT | C_GRA | C_RIN, 5'd0);
      // ALU range edges 00011 and 01011
      fetch(32'h18000000);
      add(0, 32'h18000000, 0, 1, C_GRB | C_ROUT | C_YIN, 5'd0);
      add(0, 32'h18000000, 0, 1, C_GRC | C_ROUT | C_ZHIGHIN | C_ZLOWIN, 5'b00011);
      add(0, 32'h18000000, 0, 1, C_ZLOWOUT | C_GRA | C_RIN, 5'd0);
      fetch(32'h58000000);
      add(0, 32'h58000000, 0, 1, C_GRB | C_ROUT | C_YIN, 5'd0);
      add(0, 32'h58000000, 0, 1, C_GRC | C_ROUT | C_ZHIGHIN | C_ZLOWIN, 5'b01011);
      add(0, 32'h58000000, 0, 1, C_ZLOWOUT | C_GRA | C_RIN, 5'd0);
      // 01100 is just past the ALU range: behaves as NOP
      fetch(32'h60000000);
      add(0, 32'h60000000, 0, 1, 29'd0, 5'd0);
      // BRMI taken
      fetch(32'h9B180019);
      add(0, 32'h9B180019, 0, 1, C_GRA | C_ROUT | C_CONIN, 5'd0);
      add(0, 32'h9B180019, 1, 1, C_PCOUT | C_YIN, 5'd0);
      add(0, 32'h9B180019, 1, 1, C_COUT | C_ZHIGHIN | C_ZLOWIN, ADD);
      add(0, 32'h9B180019, 1, 1, C_ZLOWOUT | C_PCIN, 5'd0);
      // BRZR not taken
      fetch(32'h9B000019);
      add(0, 32'h9B000019, 0, 1, C_GRA | C_ROUT | C_CONIN, 5'd0);
      add(0, 32'h9B000019, 0, 1, C_PCOUT | C_YIN, 5'd0);
      add(0, 32'h9B000019, 0, 1, C_COUT | C_ZHIGHIN | C_ZLOWIN, ADD);
      add(0, 32'h9B000019, 0, 1, C_ZLOWOUT, 5'd0);
      // ST then LD
      fetch(32'h11A00005);
      add(0, 32'h11A00005, 0, 1, W_ADDR3, 5'd0);
      add(0, 32'h11A00005, 0, 1, W_ADDR4, ADD);
      add(0, 32'h11A00005, 0, 1, W_ADDR5, 5'd0);
      add(0, 32'h11A00005, 0, 1, C_GRA | C_ROUT | C_MDRIN, 5'd0);
      add(0, 32'h11A00005, 0, 1, C_WRITE, 5'd0);
      fetch(32'h02000005);
      add(0, 32'h02000005, 0, 1, W_ADDR3, 5'd0);
      add(0, 32'h02000005, 0, 1, W_ADDR4, ADD);
      add(0, 32'h02000005, 0, 1, W_ADDR5, 5'd0);
      add(0, 32'h02000005, 0, 1, C_READ | C_MDRIN, 5'd0);
      add(0, 32'h02000005, 0, 1, C_MDROUT | C_GRA | C_RIN, 5'd0);
      // JR, NOP, unlisted opcode
      fetch(32'hA0800000);
      add(0, 32'hA0800000, 0, 1, C_GRA | C_ROUT | C_PCIN, 5'd0);
      fetch(32'hD0000000);
      add(0, 32'hD0000000, 0, 1, 29'd0, 5'd0);
      fetch(32'hF8000000);
      add(0, 32'hF8000000, 0, 1, 29'd0, 5'd0);
      add(0, 32'h0, 0, 1, W_F0, 5'd0);

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].clr, vecs[i].ir, vecs[i].con, vecs[i].chk,
              vecs[i].word, vecs[i].op, vecs[i].run, $sformatf("vec%0d", i));

      // Clear for two cycles during LD T5 (T0 of this LD was the last table entry)
      step(0, 32'h02000005, 0, 1, W_F1, 5'd0, 1, "ldclr_t1");
      step(0, 32'h02000005, 0, 1, W_F2, 5'd0, 1, "ldclr_t2");
      step(0, 32'h02000005, 0, 1, W_ADDR3, 5'd0, 1, "ldclr_t3");
      step(0, 32'h02000005, 0, 1, W_ADDR4, ADD, 1, "ldclr_t4");
      step(1, 32'h02000005, 0, 1, W_ADDR5, 5'd0, 1, "ldclr_t5");
      step(1, 32'h02000005, 0, 1, 29'd0, 5'd0, 1, "ldclr_reset1");
      step(0, 32'h02000005, 0, 1, 29'd0, 5'd0, 1, "ldclr_reset2");
      step(0, 32'h02000005, 0, 1, W_F0, 5'd0, 1, "ldclr_t0");
      step(0, 32'h02000005, 0, 1, W_F1, 5'd0, 1, "ldclr_t1b");

      // Clear during ST T6: Write must not appear in the following cycle
      step(0, 32'h11A00005, 0, 1, W_F2, 5'd0, 1, "stclr_t2");
      step(0, 32'h11A00005, 0, 1, W_ADDR3, 5'd0, 1, "stclr_t3");
      step(0, 32'h11A00005, 0, 1, W_ADDR4, ADD, 1, "stclr_t4");
      step(0, 32'h11A00005, 0, 1, W_ADDR5, 5'd0, 1, "stclr_t5");
      step(1, 32'h11A00005, 0, 1, C_GRA | C_ROUT | C_MDRIN, 5'd0, 1, "stclr_t6");
      step(0, 32'h11A00005, 0, 1, 29'd0, 5'd0, 1, "stclr_nowrite");
      step(0, 32'hD8000000, 0, 1, W_F0, 5'd0, 1, "hlt_t0");

      // HALT opcode
      step(0, 32'hD8000000, 0, 1, W_F1, 5'd0, 1, "hlt_t1");
      step(0, 32'hD8000000, 0, 1, W_F2, 5'd0, 1, "hlt_t2");
      step(0, 32'hD8000000, 0, 1, 29'd0, 5'd0, 1, "hlt_t3");
`ifdef CU_HALT_EN
      for (int i = 0; i < 20; i++)
         step(0, 32'hD8000000, 0, 1, 29'd0, 5'd0, 0, $sformatf("halt_hold%0d", i));
      step(1, 32'hD8000000, 0, 1, 29'd0, 5'd0, 0, "halt_clr");
      step(0, 32'hD8000000, 0, 1, 29'd0, 5'd0, 1, "halt_reset");
      step(0, 32'hD8000000, 0, 1, W_F0, 5'd0, 1, "halt_t0");
`else
      step(0, 32'hD8000000, 0, 1, W_F0, 5'd0, 1, "hltnop_t0");
      step(0, 32'hD8000000, 0, 1, W_F1, 5'd0, 1, "hltnop_t1");
      step(0, 32'hD8000000, 0, 1, W_F2, 5'd0, 1, "hltnop_t2");
      step(0, 32'hD8000000, 0, 1, 29'd0, 5'd0, 1, "hltnop_t3");
      step(0, 32'hD8000000, 0, 1, W_F0, 5'd0, 1, "hltnop_t0b");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
